multibank_pingpong_ram: RTL and testbench
=========================================

# multibank_pingpong_ram

Parametrised, single-clock multi-bank buffer RAM that lets a producer fill one bank while a consumer drains earlier committed banks. It generalises a two-sector ping-pong scheme to NUM_BANKS banks in a circular bank queue, and adds:
- configurable width and depth;
- per-bank frame length capture;
- registered read data with a valid strobe;
- sticky protocol-error flags.

It sits between a sample-capture stage and the FFT input stage, where both run on the same clock.

## Interface
Parameters:
- DATA_W, 16, data word width
- ADDR_W, 7, word address width within one bank (bank depth = 2^ADDR_W)
- NUM_BANKS, 2, number of banks; power of two, 2..8. Derived: BANK_W = log2(NUM_BANKS), LVL_W = BANK_W+1

Ports:
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- wr_addr  in  ADDR_W  write word address within current write bank
- wr_en  in  1  write strobe
- wr_data  in  DATA_W  write data
- wr_finish  in  1  commit current write bank (single-cycle pulse)
- wr_ready  out  1  a free bank is available for writing
- wr_bank  out  BANK_W  index of current write bank
- rd_addr  in  ADDR_W  read word address within current read bank
- rd_en  in  1  read strobe
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  rd_data holds the result of an accepted read
- rd_finish  in  1  release current read bank (single-cycle pulse)
- rd_ready  out  1  a committed bank is available for reading
- rd_bank  out  BANK_W  index of current read bank
- rd_len  out  ADDR_W+1  write count captured for current read bank
- level  out  LVL_W  number of committed, unreleased banks (0..NUM_BANKS)
- err_wr  out  1  sticky: wr_en or wr_finish seen while wr_ready=0
- err_rd  out  1  sticky: rd_en or rd_finish seen while rd_ready=0

## Operation
- Memory is an inferred simple dual-port RAM of NUM_BANKS·2^ADDR_W words.
  - Write address = {wr_ptr, wr_addr}; read address = {rd_ptr, rd_addr}.
- State registers:
  - wr_ptr and rd_ptr: BANK_W bits each, wrap modulo NUM_BANKS;
  - level;
  - wr_cnt: ADDR_W+1 bits;
  - len[NUM_BANKS]: ADDR_W+1 bits each;
  - err_wr, err_rd.
- Outputs are decoded from registers only:
  - wr_ready = (level != NUM_BANKS); rd_ready = (level != 0);
  - wr_bank = wr_ptr; rd_bank = rd_ptr; rd_len = len[rd_ptr].
- Accepted write (wr_en & wr_ready):
  - RAM is written;
  - wr_cnt increments, saturating at 2^ADDR_W (counts writes, not distinct addresses).
- Accepted commit (wr_finish & wr_ready):
  - len[wr_ptr] <= wr_cnt plus 1 if a write is accepted in the same cycle (that write belongs to the committed bank), saturated;
  - wr_ptr increments; wr_cnt clears to 0.
  - A commit with zero writes is legal and records length 0.
- Accepted release (rd_finish & rd_ready): rd_ptr increments.
- level update:
  - commit only: +1;
  - release only: -1;
  - both in the same cycle: unchanged, and both pointers advance.
- Rejected strobes (wr_en/wr_finish when full, rd_en/rd_finish when empty):
  - no state change other than setting the matching sticky error flag;
  - the RAM is not written.
- Bank exclusion holds by construction.
  - The write bank is never committed-and-unreleased while wr_ready=1.
  - The read bank is always committed while rd_ready=1.
  - Read and write therefore never address the same bank.
- Error flags clear only on reset.
- Reset (asynchronous, may occur mid-frame):
  - pointers, level, wr_cnt and all len entries go to 0; RAM contents are not cleared;
  - all outputs take reset values: wr_ready=1, rd_ready=0, wr_bank=0, rd_bank=0, rd_len=0, level=0, rd_data=0, rd_valid=0, err_wr=0, err_rd=0.
  - Reset deassertion must be synchronised externally to clk.

## Timing
- Write: data lands in RAM at the clk edge sampling wr_en. Write-to-read visibility within the same bank is not applicable.
- Read latency is 1 cycle.
  - rd_en & rd_ready sampled at edge N → rd_data and rd_valid=1 after edge N.
  - rd_valid=0 after any edge without an accepted read.
  - rd_data holds its last value when no read is accepted.
- Commit/release latency is 1 cycle.
  - wr_finish sampled at edge N → wr_bank, level and rd_ready updated after edge N.
  - rd_ready can first be 1 in the cycle after the commit.
  - A consumer may issue rd_en in that cycle.
- Full: once level=NUM_BANKS, wr_ready=0 from the cycle after the filling commit.
  - wr_ready returns to 1 the cycle after an accepted release.
- No combinational path from any input to wr_ready, rd_ready, wr_bank, rd_bank, level or rd_len.

## Test plan
- Reset then idle → wr_ready=1, rd_ready=0, level=0, rd_valid=0, err_wr=0, err_rd=0; after rstn pulses low mid-frame, the same values hold immediately, asynchronously.
- NUM_BANKS=2, ADDR_W=7: write 128 words (data=addr) to bank 0 with wr_finish on the last write; read addr 0..127 → rd_len=128, rd_data=addr one cycle after each rd_en; rd_finish → level=0, rd_bank=1.
- NUM_BANKS=4: commit 4 frames of lengths 3, 0, 128, 5 without reads → level=4, wr_ready=0; an extra wr_en sets err_wr, leaves wr_cnt unchanged and writes nothing; reading the banks back in order gives rd_len 3, 0, 128, 5 and correct data.
- level=1 with wr_finish and rd_finish asserted in the same cycle → level stays 1, wr_bank and rd_bank both advance, the new rd_len equals the just-committed count.
- Writer wraps: 10 commit/release cycles with NUM_BANKS=2 → wr_bank/rd_bank toggle 0,1,0,…; data in each frame never corrupted by the other frame's writes.
- rd_finish and rd_en while level=0 → err_rd=1, rd_ptr unchanged, rd_valid=0; err_rd stays 1 until reset.

Source files
------------

// File: rtl/multibank_pingpong_ram.sv
// multibank_pingpong_ram: circular queue of NUM_BANKS RAM banks. A producer
// fills the bank at wr_ptr while a consumer drains committed banks starting at
// rd_ptr. Each bank records how many words were written before it was
// committed, and misuse of either side raises a sticky error flag.
module multibank_pingpong_ram #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 7,
  parameter int NUM_BANKS = 2,
  localparam int BANK_W   = $clog2(NUM_BANKS),
  localparam int LVL_W    = BANK_W + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_finish,
  output logic              wr_ready,
  output logic [BANK_W-1:0] wr_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_finish,
  output logic              rd_ready,
  output logic [BANK_W-1:0] rd_bank,
  output logic [ADDR_W:0]   rd_len,
  output logic [LVL_W-1:0]  level,
  output logic              err_wr,
  output logic              err_rd
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int WORDS = NUM_BANKS * DEPTH;
  localparam logic [ADDR_W:0]  CNT_MAX  = (ADDR_W + 1)'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(NUM_BANKS);

  // Word counter increment that sticks at a full bank's worth of writes.
  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic [DATA_W-1:0] mem [WORDS];
  logic [BANK_W-1:0] wr_ptr;
  logic [BANK_W-1:0] rd_ptr;
  logic [LVL_W-1:0]  lvl;
  logic [ADDR_W:0]   wr_cnt;
  logic [ADDR_W:0]   len [NUM_BANKS];
  logic [DATA_W-1:0] rd_data_p1;
  logic              vld_p1;
  logic              err_wr_q;
  logic              err_rd_q;

  logic            wr_acc;
  logic            commit;
  logic            rd_acc;
  logic            rel;
  logic [ADDR_W:0] wr_cnt_next;

  // Ready flags depend only on the registered fill level, so no input can
  // reach them combinationally.
  assign wr_ready = (lvl != LVL_FULL);
  assign rd_ready = (lvl != '0);
  assign wr_bank  = wr_ptr;
  assign rd_bank  = rd_ptr;
  assign rd_len   = len[rd_ptr];
  assign level    = lvl;
  assign rd_data  = rd_data_p1;
  assign rd_valid = vld_p1;
  assign err_wr   = err_wr_q;
  assign err_rd   = err_rd_q;

  assign wr_acc      = wr_en & wr_ready;
  assign commit      = wr_finish & wr_ready;
  assign rd_acc      = rd_en & rd_ready;
  assign rel         = rd_finish & rd_ready;
  // A write accepted together with the commit still belongs to the old bank.
  assign wr_cnt_next = wr_acc ? sat_inc(wr_cnt) : wr_cnt;

  // RAM write port; contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[{wr_ptr, wr_addr}] <= wr_data;
  end

  // ---- stage p1: registered read port, data held when no read is accepted
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= rd_acc;
      if (rd_acc) rd_data_p1 <= mem[{rd_ptr, rd_addr}];
    end
  end

  // Writer side: word count, bank pointer and per-bank length capture.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      wr_cnt <= '0;
      for (int i = 0; i < NUM_BANKS; i++) len[i] <= '0;
    end else if (commit) begin
      len[wr_ptr] <= wr_cnt_next;
      wr_ptr      <= wr_ptr + 1'b1;
      wr_cnt      <= '0;
    end else begin
      wr_cnt <= wr_cnt_next;
    end
  end

  // Reader pointer and fill level; a simultaneous commit and release cancel.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      lvl    <= '0;
    end else begin
      if (rel) rd_ptr <= rd_ptr + 1'b1;
      if (commit && !rel)      lvl <= lvl + 1'b1;
      else if (rel && !commit) lvl <= lvl - 1'b1;
    end
  end

  // Sticky protocol-error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_wr_q <= 1'b0;
      err_rd_q <= 1'b0;
    end else begin
      if ((wr_en | wr_finish) & ~wr_ready) err_wr_q <= 1'b1;
      if ((rd_en | rd_finish) & ~rd_ready) err_rd_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multibank_pingpong_ram.sv
// Self-checking bench for multibank_pingpong_ram (4 banks of 128 words).
// Reference model: a frame-level view of the buffer (bank contents, per-bank
// lengths, fill count, sticky flags) updated per cycle from the protocol rules.
module tb_multibank_pingpong_ram;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 7;
  localparam int NB     = 4;
  localparam int BANK_W = 2;
  localparam int LVL_W  = 3;
  localparam int DEPTH  = 128;

  logic              clk;
  logic              rstn;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              wr_finish;
  logic              wr_ready;
  logic [BANK_W-1:0] wr_bank;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_finish;
  logic              rd_ready;
  logic [BANK_W-1:0] rd_bank;
  logic [ADDR_W:0]   rd_len;
  logic [LVL_W-1:0]  level;
  logic              err_wr;
  logic              err_rd;

  multibank_pingpong_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_BANKS(NB)) dut (
    .clk(clk), .rstn(rstn),
    .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data), .wr_finish(wr_finish),
    .wr_ready(wr_ready), .wr_bank(wr_bank),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_finish(rd_finish), .rd_ready(rd_ready), .rd_bank(rd_bank), .rd_len(rd_len),
    .level(level), .err_wr(err_wr), .err_rd(err_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [DATA_W-1:0] m_mem [NB][DEPTH];
  bit                m_known [NB][DEPTH];
  int                m_len [NB];
  int                m_lvl, m_wb, m_rb, m_wcnt;
  bit                m_errw, m_errr, m_vld, m_data_known;
  logic [DATA_W-1:0] m_data;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lvl = 0; m_wb = 0; m_rb = 0; m_wcnt = 0;
    for (int i = 0; i < NB; i++) m_len[i] = 0;
    m_errw = 0; m_errr = 0; m_vld = 0;
    m_data = '0; m_data_known = 1;
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, "_wr_ready"}, 32'(wr_ready), 32'(m_lvl != NB));
    chk({ph, "_rd_ready"}, 32'(rd_ready), 32'(m_lvl != 0));
    chk({ph, "_wr_bank"},  32'(wr_bank),  32'(m_wb));
    chk({ph, "_rd_bank"},  32'(rd_bank),  32'(m_rb));
    chk({ph, "_rd_len"},   32'(rd_len),   32'(m_len[m_rb]));
    chk({ph, "_level"},    32'(level),    32'(m_lvl));
    chk({ph, "_rd_valid"}, 32'(rd_valid), 32'(m_vld));
    chk({ph, "_err_wr"},   32'(err_wr),   32'(m_errw));
    chk({ph, "_err_rd"},   32'(err_rd),   32'(m_errr));
    if (m_data_known) chk({ph, "_rd_data"}, 32'(rd_data), 32'(m_data));
  endtask

  // One clock cycle: drive strobes, advance the model, check after the edge.
  task automatic cyc(input bit we, input int wa, input logic [DATA_W-1:0] wd,
                     input bit wf, input bit re, input int ra, input bit rf);
    bit wok, rok;
    wr_en = we; wr_addr = wa[ADDR_W-1:0]; wr_data = wd; wr_finish = wf;
    rd_en = re; rd_addr = ra[ADDR_W-1:0]; rd_finish = rf;
    wok = (m_lvl != NB);
    rok = (m_lvl != 0);
    if (re && rok) begin
      m_vld = 1;
      m_data = m_mem[m_rb][ra % DEPTH];
      m_data_known = m_known[m_rb][ra % DEPTH];
    end else begin
      m_vld = 0;
    end
    if ((re || rf) && !rok) m_errr = 1;
    if ((we || wf) && !wok) m_errw = 1;
    if (we && wok) begin
      m_mem[m_wb][wa % DEPTH] = wd;
      m_known[m_wb][wa % DEPTH] = 1;
      if (m_wcnt < DEPTH) m_wcnt++;
    end
    if (wf && wok) begin
      m_len[m_wb] = m_wcnt;
      m_wb = (m_wb + 1) % NB;
      m_wcnt = 0;
      m_lvl++;
    end
    if (rf && rok) begin
      m_rb = (m_rb + 1) % NB;
      m_lvl--;
    end
    @(posedge clk);
    #1;
    check_outputs("cyc");
  endtask

  task automatic idle();
    cyc(0, 0, '0, 0, 0, 0, 0);
  endtask

  // Write a frame of n words at addresses 0..n-1, committing on the last one.
  task automatic write_frame(input int n, input bit addr_data);
    logic [DATA_W-1:0] d;
    if (n == 0) cyc(0, 0, '0, 1, 0, 0, 0);
    for (int i = 0; i < n; i++) begin
      d = addr_data ? DATA_W'(i) : DATA_W'($urandom);
      cyc(1, i, d, (i == n - 1), 0, 0, 0);
    end
  endtask

  // Read n words of the current read bank, then release it.
  task automatic read_frame(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, 1, i, 0);
    cyc(0, 0, '0, 0, 0, 0, 1);
  endtask

  initial begin
    int lens [4];
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++) m_known[b][a] = 0;
    rstn = 1'b0;
    wr_en = 0; wr_addr = '0; wr_data = '0; wr_finish = 0;
    rd_en = 0; rd_addr = '0; rd_finish = 0;
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) idle();

    // Full-depth frame with data = address, read back in order.
    write_frame(DEPTH, 1);
    chk("full_frame_rd_len", 32'(rd_len), 32'(DEPTH));
    read_frame(DEPTH);

    // Fill every bank with frames of 3, 0, 128, 5 words; overflow attempt.
    lens = '{3, 0, 128, 5};
    for (int f = 0; f < 4; f++) write_frame(lens[f], 0);
    chk("full_wr_ready", 32'(wr_ready), 32'(0));
    cyc(1, 0, 16'hBEEF, 0, 0, 0, 0);
    chk("overflow_err_wr", 32'(err_wr), 32'(1));
    for (int f = 0; f < 4; f++) begin
      chk("drain_rd_len", 32'(rd_len), 32'(lens[f]));
      read_frame(lens[f]);
    end

    // Simultaneous commit and release at level 1.
    write_frame(4, 0);
    cyc(1, 0, DATA_W'($urandom), 0, 0, 0, 0);
    cyc(1, 1, DATA_W'($urandom), 1, 0, 0, 1);
    chk("simul_level", 32'(level), 32'(1));
    chk("simul_rd_len", 32'(rd_len), 32'(2));
    read_frame(2);

    // Ten frames written while the previous frame is read, swapping together.
    for (int k = 0; k < 10; k++)
      for (int i = 0; i < 8; i++)
        cyc(1, i, DATA_W'($urandom), (i == 7), (k > 0), i, (k > 0 && i == 7));
    read_frame(8);

    // Asynchronous reset in the middle of a frame with a read in flight.
    write_frame(3, 0);
    cyc(1, 0, DATA_W'($urandom), 0, 1, 1, 0);
    cyc(1, 1, DATA_W'($urandom), 0, 0, 0, 0);
    wr_en = 0; wr_finish = 0; rd_en = 0; rd_finish = 0;
    rstn = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    @(negedge clk);
    rstn = 1'b1;
    idle();

    // Read-side misuse while empty.
    cyc(0, 0, '0, 0, 1, 3, 1);
    chk("empty_err_rd", 32'(err_rd), 32'(1));
    chk("empty_rd_valid", 32'(rd_valid), 32'(0));
    repeat (3) idle();
    write_frame(2, 0);
    read_frame(2);
    chk("sticky_err_rd", 32'(err_rd), 32'(1));

    // Randomised traffic including protocol violations.
    for (int n = 0; n < 600; n++)
      cyc($urandom_range(0, 1), $urandom_range(0, DEPTH - 1), DATA_W'($urandom),
          ($urandom_range(0, 15) == 0), $urandom_range(0, 1),
          $urandom_range(0, DEPTH - 1), ($urandom_range(0, 9) == 0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
